// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam int          BUF_DEPTH = 2;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Fetch sequencing: free to request, waiting for a kept response,
    // or waiting for a response that a redirect has made stale.
    typedef enum logic [1:0] {
        IDLE_REQ  = 2'd0,
        WAIT      = 2'd1,
        WAIT_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem request/response, redirect, and decoder handshake.
interface fetch_unit_if #(parameter int XLEN = 32);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    // Environment side: memory, branch logic and decoder.
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_unit_buf.sv
// Two-entry instruction queue with flush; head is a registered entry.
module fetch_buf
    import core_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush discards everything queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, and a
// two-entry queue feeding the decoder; redirects flush queued and in-flight work.
module fetch_unit #(
    parameter int              XLEN      = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
    parameter int              BUF_DEPTH = core_pkg::BUF_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  io
);

    import core_pkg::*;

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            outstanding;
    logic            accept;
    logic            push;
    logic            pop;
    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign outstanding = (state != IDLE_REQ);

    // A queue slot is reserved at request time, so responses never stall.
    assign io.imem_req_valid = !reset && !outstanding &&
                               ((32'(count) + 32'(outstanding)) < 32'(BUF_DEPTH));
    assign io.imem_req_addr  = reset ? RESET_PC : pc;
    assign accept            = io.imem_req_valid && io.imem_req_ready;

    // Only a response belonging to a still-current request is kept.
    assign push = io.imem_rsp_valid && (state == WAIT) && !io.redirect_valid;
    assign pop  = io.inst_valid && io.inst_ready;

    assign push_entry.inst = io.imem_rsp_data;
    assign push_entry.pc   = inflight_pc;

    assign io.inst_valid = !reset && (count != 2'd0);
    assign io.inst       = reset ? 32'h0 : head.inst;
    assign io.inst_pc    = reset ? '0 : head.pc;

    // Request-tracking state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE_REQ;
        else       state <= state_nxt;
    end

    // Next state: a redirect turns any live request into one to discard.
    always_comb begin
        state_nxt = state;
        if (io.redirect_valid) begin
            case (state)
                IDLE_REQ: if (accept) state_nxt = WAIT_DROP;
                default:  state_nxt = io.imem_rsp_valid ? IDLE_REQ : WAIT_DROP;
            endcase
        end else begin
            case (state)
                IDLE_REQ:  if (accept) state_nxt = WAIT;
                WAIT:      if (io.imem_rsp_valid) state_nxt = IDLE_REQ;
                WAIT_DROP: if (io.imem_rsp_valid) state_nxt = IDLE_REQ;
                default:   state_nxt = IDLE_REQ;
            endcase
        end
    end

    // PC advance on accept; a redirect overrides and suppresses the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
        end else begin
            if (io.redirect_valid)
                pc <= {io.redirect_pc[XLEN-1:2], 2'b00};
            else if (accept)
                pc <= pc + XLEN'(4);
            if (accept) inflight_pc <= pc;
        end
    end

    fetch_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (io.redirect_valid),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, ready stall,
// PC wrap (second instance) and mid-fetch reset.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) f ();
    fetch_unit_if #(.XLEN(32)) w ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (f.master)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .io    (w.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d);
        f.imem_rsp_valid = v;
        f.imem_rsp_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        f.imem_req_ready = 1'b0; f.imem_rsp_valid = 1'b0; f.imem_rsp_data = '0;
        f.redirect_valid = 1'b0; f.redirect_pc = '0; f.inst_ready = 1'b0;
        w.imem_req_ready = 1'b1; w.imem_rsp_valid = 1'b0; w.imem_rsp_data = '0;
        w.redirect_valid = 1'b0; w.redirect_pc = '0; w.inst_ready = 1'b1;
        #1;
        chk("rst_reqv", f.imem_req_valid, 0);
        chk("rst_instv", f.inst_valid, 0);
        chk("rst_addr", f.imem_req_addr, 32'h0);
        tick(); tick();
        chk("rst_inst", f.inst, 0);
        chk("rst_instpc", f.inst_pc, 0);
        chk("rst_waddr", w.imem_req_addr, 32'hFFFF_FFFC);

        // Streaming: 1-cycle latency, decoder always ready.
        reset = 1'b0; f.imem_req_ready = 1'b1; f.inst_ready = 1'b1; #1;
        chk("s0_reqv", f.imem_req_valid, 1);
        chk("s0_addr", f.imem_req_addr, 32'h0);
        chk("w0_addr", w.imem_req_addr, 32'hFFFF_FFFC);
        tick();
        rsp(1, 32'hA000_0000); w.imem_rsp_valid = 1'b1; w.imem_rsp_data = 32'hB000_0000; #1;
        chk("s1_reqv", f.imem_req_valid, 0);
        chk("s1_instv", f.inst_valid, 0);
        tick();
        rsp(0, 0); w.imem_rsp_valid = 1'b0; #1;
        chk("s2_instv", f.inst_valid, 1);
        chk("s2_inst", f.inst, 32'hA000_0000);
        chk("s2_pc", f.inst_pc, 32'h0);
        chk("s2_addr", f.imem_req_addr, 32'h4);
        chk("w_wrap_addr", w.imem_req_addr, 32'h0);
        chk("w_wrap_reqv", w.imem_req_valid, 1);
        chk("w_instpc", w.inst_pc, 32'hFFFF_FFFC);
        tick();
        rsp(1, 32'hA000_0004); #1;
        chk("s3_instv", f.inst_valid, 0);
        tick();
        rsp(0, 0); #1;
        chk("s4_pc", f.inst_pc, 32'h4);
        chk("s4_inst", f.inst, 32'hA000_0004);
        chk("s4_addr", f.imem_req_addr, 32'h8);
        tick();
        rsp(1, 32'hA000_0008); #1;
        tick();

        // Decoder stall fills the queue.
        rsp(0, 0); f.inst_ready = 1'b0; #1;
        chk("s6_pc", f.inst_pc, 32'h8);
        chk("s6_inst", f.inst, 32'hA000_0008);
        chk("s6_addr", f.imem_req_addr, 32'hC);
        chk("s6_reqv", f.imem_req_valid, 1);
        tick();
        rsp(1, 32'hA000_000C); #1;
        tick();
        rsp(0, 0); #1;
        chk("st_full_reqv", f.imem_req_valid, 0);
        chk("st_full_pc", f.inst_pc, 32'h8);
        tick();
        chk("st_full_reqv2", f.imem_req_valid, 0);
        f.inst_ready = 1'b1; #1;
        chk("st_pop_pc", f.inst_pc, 32'h8);
        tick();
        f.inst_ready = 1'b0; #1;
        chk("st_next_pc", f.inst_pc, 32'hC);
        chk("st_next_inst", f.inst, 32'hA000_000C);
        chk("st_next_reqv", f.imem_req_valid, 1);
        chk("st_next_addr", f.imem_req_addr, 32'h10);
        tick();

        // Redirect while a request is in flight; its late response is stale.
        f.redirect_valid = 1'b1; f.redirect_pc = 32'h100; #1;
        chk("rw_reqv", f.imem_req_valid, 0);
        tick();
        f.redirect_valid = 1'b0; #1;
        chk("rw_instv", f.inst_valid, 0);
        chk("rw_reqv2", f.imem_req_valid, 0);
        tick();
        rsp(1, 32'hDEAD_0010); #1;
        tick();
        rsp(0, 0); #1;
        chk("rw_drop_instv", f.inst_valid, 0);
        chk("rw_reqv3", f.imem_req_valid, 1);
        chk("rw_addr", f.imem_req_addr, 32'h100);
        tick();
        rsp(1, 32'hA000_0100); #1;
        tick();
        rsp(0, 0); #1;
        chk("rw_pc", f.inst_pc, 32'h100);
        chk("rw_inst", f.inst, 32'hA000_0100);
        chk("rw_addr2", f.imem_req_addr, 32'h104);

        // Redirect coinciding with an accept, then with that response.
        f.redirect_valid = 1'b1; f.redirect_pc = 32'h203; #1;
        chk("ra_reqv", f.imem_req_valid, 1);
        tick();
        f.redirect_valid = 1'b0; #1;
        chk("ra_instv", f.inst_valid, 0);
        chk("ra_reqv2", f.imem_req_valid, 0);
        chk("ra_addr", f.imem_req_addr, 32'h200);
        tick();
        rsp(1, 32'hDEAD_0204); f.redirect_valid = 1'b1; #1;
        tick();
        rsp(0, 0); f.redirect_valid = 1'b0; #1;
        chk("ra_instv2", f.inst_valid, 0);
        chk("ra_reqv3", f.imem_req_valid, 1);
        chk("ra_addr2", f.imem_req_addr, 32'h200);

        // Memory not ready: address holds.
        f.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_reqv", f.imem_req_valid, 1);
            chk("hold_addr", f.imem_req_addr, 32'h200);
            tick();
        end
        f.imem_req_ready = 1'b1; #1;
        tick();
        rsp(1, 32'hA000_0200); #1;
        tick();
        rsp(0, 0); #1;
        chk("hold_pc", f.inst_pc, 32'h200);
        chk("hold_inst", f.inst, 32'hA000_0200);
        chk("hold_addr2", f.imem_req_addr, 32'h204);
        tick();

        // Reset with a queued entry and a request outstanding.
        reset = 1'b1; #1;
        chk("mr_reqv", f.imem_req_valid, 0);
        chk("mr_instv", f.inst_valid, 0);
        chk("mr_addr", f.imem_req_addr, 32'h0);
        tick();
        reset = 1'b0; #1;
        chk("mr_instv2", f.inst_valid, 0);
        chk("mr_reqv2", f.imem_req_valid, 1);
        chk("mr_addr2", f.imem_req_addr, 32'h0);
        tick();
        rsp(1, 32'hA000_0000); #1;
        tick();
        rsp(0, 0); #1;
        chk("mr_pc", f.inst_pc, 32'h0);
        chk("mr_instv3", f.inst_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
